// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths, the zero-register constant and the aux queue entry type
package regfile_write_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } q_entry_t;
endpackage

// File: rtl/regfile_wr_queue.sv
// regfile_wr_queue: in-order circular buffer of pending aux writes with per-entry live bits
//   push_i/push_rd_i/push_data_i : enqueue a live entry at the tail (ignored when full)
//   pop_i                        : retire the head entry (ignored when empty)
//   kill_i/kill_rd_i             : mark every valid entry writing kill_rd_i dead
//   q_reg1_i/q_reg2_i -> hit1_o/hit2_o : valid live entry targets the queried register
//   head_o/head_valid_o/count_o  : head entry, its validity and current occupancy
module regfile_wr_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_rd_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [ADDR_W-1:0]        kill_rd_i,
  input  logic [ADDR_W-1:0]        q_reg1_i,
  input  logic [ADDR_W-1:0]        q_reg2_i,
  output q_entry_t                 head_o,
  output logic                     head_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     hit1_o,
  output logic                     hit2_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  q_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign do_push = push_i && cnt_q != FULL;
  assign do_pop = pop_i && vld_q[rd_ptr_q];
  assign head_o = mem_q[rd_ptr_q];
  assign head_valid_o = vld_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Kill is applied before the push so a same-cycle enqueue of the killed register stays live.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (kill_i && vld_q[i] && mem_q[i].rd == kill_rd_i) mem_d[i].live = 1'b0;
    if (do_pop) vld_d[rd_ptr_q] = 1'b0;
    if (do_push) begin
      mem_d[wr_ptr_q] = '{live: 1'b1, rd: push_rd_i, data: push_data_i};
      vld_d[wr_ptr_q] = 1'b1;
    end
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_comb begin
    hit1_o = 1'b0;
    hit2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1_o = hit1_o | (vld_q[i] && mem_q[i].live && mem_q[i].rd == q_reg1_i && q_reg1_i != REG_ZERO);
      hit2_o = hit2_o | (vld_q[i] && mem_q[i].live && mem_q[i].rd == q_reg2_i && q_reg2_i != REG_ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '0;
      vld_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between WB (priority) and a queued aux unit
//   wb_valid/wb_reg/wb_data        : pipeline writeback, no backpressure
//   aux_valid/aux_ready/aux_reg/aux_data : multi-cycle unit results, valid/ready
//   rf_regWrite/rf_writeReg/rf_writeData : register file write port, zero latency
//   stall_wb      : registered request for WB to hold while a starved aux head drains
//   q_reg1/q_reg2 -> q_hit1/q_hit2 : decode hazard lookup against pending aux writes
//   protocol_err  : sticky flag, WB wrote while stall_wb was asserted
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_reg,
  input  logic [DATA_W-1:0] aux_data,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              stall_wb,
  input  logic [ADDR_W-1:0] q_reg1,
  input  logic [ADDR_W-1:0] q_reg2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic              protocol_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] LIM1 = WW'(STARVE_LIMIT - 1);
  q_entry_t head;
  logic head_valid, wb_live, live_head, drain, pop, push;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_q, wait_d;
  logic stall_q, stall_d, err_q, err_d;

  assign wb_live = wb_valid && wb_reg != REG_ZERO;
  assign live_head = head_valid && head.live;
  assign drain = live_head && !wb_live;
  // A dead head retires every cycle it is present; a live one only when WB leaves the port free.
  assign pop = head_valid && !(head.live && wb_live);
  assign aux_ready = rst_n && count != FULL;
  // Writes to r0 are handshaken but never stored.
  assign push = aux_valid && aux_ready && aux_reg != REG_ZERO;

  assign rf_regWrite = wb_live || live_head;
  assign rf_writeReg = wb_live ? wb_reg : live_head ? head.rd : REG_ZERO;
  assign rf_writeData = wb_live ? wb_data : live_head ? head.data : '0;
  assign stall_wb = stall_q;
  assign protocol_err = err_q;

  regfile_wr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (aux_reg),
    .push_data_i (aux_data),
    .pop_i       (pop),
    .kill_i      (wb_live),
    .kill_rd_i   (wb_reg),
    .q_reg1_i    (q_reg1),
    .q_reg2_i    (q_reg2),
    .head_o      (head),
    .head_valid_o(head_valid),
    .count_o     (count),
    .hit1_o      (q_hit1),
    .hit2_o      (q_hit2)
  );

  // The wait counter saturates so a WB that ignores the stall keeps it asserted.
  // Stall also drops once no live head remains, so a killed head cannot leave WB stuck.
  always_comb begin
    wait_d = (live_head && !drain) ? (wait_q == LIM1 ? wait_q : wait_q + 1'b1) : '0;
    stall_d = (drain || !live_head) ? 1'b0 : (wait_q == LIM1) ? 1'b1 : stall_q;
    err_d = err_q || (wb_valid && stall_q);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_q <= '0;
      stall_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a queue-based reference model of the write arbiter
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;
  localparam int DEPTH = 4;
  localparam int LIM = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_valid = 1'b0, aux_valid = 1'b0;
  logic [ADDR_W-1:0] wb_reg = '0, aux_reg = '0, q_reg1 = '0, q_reg2 = '0;
  logic [DATA_W-1:0] wb_data = '0, aux_data = '0;
  logic aux_ready, rf_regWrite, stall_wb, q_hit1, q_hit2, protocol_err;
  logic [ADDR_W-1:0] rf_writeReg;
  logic [DATA_W-1:0] rf_writeData;

  typedef struct {logic live; logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;} ment_t;
  typedef struct {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;} wr_t;
  ment_t mq[$];
  wr_t exp_wr[$];
  wr_t mon_w;
  int n_cmp = 0, n_bad = 0;
  int m_wait = 0;
  logic m_err = 1'b0;
  logic e_ready = 1'b0, e_hit1 = 1'b0, e_hit2 = 1'b0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
    .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .stall_wb(stall_wb), .q_reg1(q_reg1), .q_reg2(q_reg2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .protocol_err(protocol_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected port use and flags for the inputs now applied, from the model queue.
  task automatic model_comb();
    wr_t w;
    e_ready = mq.size() < DEPTH;
    if (wb_valid && wb_reg != 0) begin
      w.rd = wb_reg;
      w.data = wb_data;
      exp_wr.push_back(w);
    end else if (mq.size() > 0 && mq[0].live) begin
      w.rd = mq[0].rd;
      w.data = mq[0].data;
      exp_wr.push_back(w);
    end
    e_hit1 = 1'b0;
    e_hit2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].live && q_reg1 != 0 && mq[i].rd == q_reg1) e_hit1 = 1'b1;
      if (mq[i].live && q_reg2 != 0 && mq[i].rd == q_reg2) e_hit2 = 1'b1;
    end
    mon_en = 1'b1;
  endtask

  // Model state advance at a clock edge; m_wait counts cycles the current live head has been refused.
  task automatic model_commit();
    logic wl, hl, drain, pop, acc;
    ment_t e;
    wl = wb_valid && wb_reg != 0;
    hl = mq.size() > 0 && mq[0].live;
    drain = hl && !wl;
    pop = mq.size() > 0 && !(mq[0].live && wl);
    acc = aux_valid && mq.size() < DEPTH && aux_reg != 0;
    if (wb_valid && m_wait >= LIM) m_err = 1'b1;
    m_wait = (hl && !drain) ? m_wait + 1 : 0;
    if (wl) foreach (mq[i]) if (mq[i].rd == wb_reg) mq[i].live = 1'b0;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      e.live = 1'b1;
      e.rd = aux_reg;
      e.data = aux_data;
      mq.push_back(e);
    end
  endtask

  task automatic set(input logic wv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                     input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                     input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    wb_valid = wv;
    wb_reg = wr;
    wb_data = wd;
    aux_valid = av;
    aux_reg = ar;
    aux_data = ad;
    q_reg1 = r1;
    q_reg2 = r2;
    model_comb();
  endtask

  task automatic idle(input logic [ADDR_W-1:0] r1);
    set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_commit();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (rf_regWrite) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_spurious: got write r%0d=%0h, expected no write", rf_writeReg, rf_writeData);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_reg", rf_writeReg, mon_w.rd);
          chk("wr_data", rf_writeData, mon_w.data);
        end
      end else chk("idle_port", {rf_writeReg, rf_writeData}, '0);
      if (exp_wr.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_missing: got no write, expected r%0d=%0h", exp_wr[0].rd, exp_wr[0].data);
        exp_wr.delete();
      end
      chk("aux_ready", aux_ready, e_ready);
      chk("stall_wb", stall_wb, m_wait >= LIM);
      chk("protocol_err", protocol_err, m_err);
      chk("q_hit1", q_hit1, e_hit1);
      chk("q_hit2", q_hit2, e_hit2);
    end
  end

  initial begin
    #1;
    chk("rst_ready", aux_ready, 0);
    chk("rst_write", rf_regWrite, 0);
    chk("rst_stall", stall_wb, 0);
    chk("rst_err", protocol_err, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Single aux write into an idle port.
    set(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0);
    #1 chk("t1_ready", aux_ready, 1);
    chk("t1_hit_same_cycle", q_hit1, 0);
    tick();
    idle(5'd5);
    #1 chk("t1_write", rf_regWrite, 1);
    chk("t1_reg", rf_writeReg, 5);
    chk("t1_data", rf_writeData, 32'h11);
    chk("t1_hit", q_hit1, 1);
    tick();
    idle(5'd5);
    #1 chk("t1_empty", rf_regWrite, 0);
    chk("t1_hit_gone", q_hit1, 0);
    tick();
    // Fill the queue behind continuous WB traffic, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      set(1'b1, 5'd9, 32'h900 + i, 1'b1, ADDR_W'(i), 32'h100 + i, 5'd3, 5'd0);
      tick();
    end
    set(1'b1, 5'd9, 32'h905, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1 chk("t2_full_ready", aux_ready, 0);
    chk("t2_hit1", q_hit1, 1);
    chk("t2_hit2", q_hit2, 1);
    chk("t2_wb_reg", rf_writeReg, 9);
    tick();
    for (int i = 1; i <= 4; i++) begin
      idle(5'd0);
      #1 chk("t2_drain_reg", rf_writeReg, i);
      chk("t2_drain_data", rf_writeData, 32'h100 + i);
      tick();
    end
    // A newer WB write to the same register kills the queued entry.
    set(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA, 5'd0, 5'd0);
    tick();
    set(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #1 chk("t3_wb_data", rf_writeData, 32'hB);
    chk("t3_hit_before", q_hit1, 1);
    tick();
    idle(5'd7);
    #1 chk("t3_dead_no_write", rf_regWrite, 0);
    chk("t3_hit_after", q_hit1, 0);
    tick();
    idle(5'd7);
    #1 chk("t3_empty", rf_regWrite, 0);
    tick();
    // Starve a head, then violate the stall, then let the head drain.
    set(1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    tick();
    for (int k = 0; k < LIM; k++) begin
      set(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1 chk("t4_no_stall_yet", stall_wb, 0);
      tick();
    end
    set(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 chk("t4_stall", stall_wb, 1);
    chk("t5_violate_reg", rf_writeReg, 2);
    chk("t5_err_pre", protocol_err, 0);
    tick();
    idle(5'd0);
    #1 chk("t5_err", protocol_err, 1);
    chk("t5_stall_held", stall_wb, 1);
    chk("t4_drain_reg", rf_writeReg, 6);
    chk("t4_drain_data", rf_writeData, 32'h66);
    tick();
    idle(5'd0);
    #1 chk("t4_stall_clear", stall_wb, 0);
    chk("t5_err_sticky", protocol_err, 1);
    tick();
    // r0 aux writes are accepted and dropped.
    set(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    #1 chk("t6_r0_ready", aux_ready, 1);
    tick();
    idle(5'd0);
    #1 chk("t6_r0_no_write", rf_regWrite, 0);
    tick();
    // Asynchronous reset with two entries queued.
    set(1'b1, 5'd9, 32'h91, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    tick();
    set(1'b1, 5'd9, 32'h92, 1'b1, 5'd11, 32'hB0, 5'd0, 5'd0);
    tick();
    idle(5'd11);
    #1 chk("t6_pre_rst_reg", rf_writeReg, 10);
    rst_n = 1'b0;
    #1 chk("t6_rst_write", rf_regWrite, 0);
    chk("t6_rst_ready", aux_ready, 0);
    chk("t6_rst_hit", q_hit1, 0);
    chk("t6_rst_err", protocol_err, 0);
    mq.delete();
    exp_wr.delete();
    m_wait = 0;
    m_err = 1'b0;
    tick();
    chk("t6_rst_hold_write", rf_regWrite, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(5'd11);
      tick();
    end
    // Randomized traffic; WB load rises each block and obeys stall_wb.
    for (int b = 1; b <= 4; b++) begin
      for (int c = 0; c < 150; c++) begin
        set(($urandom_range(0, 3) < b) && !(m_wait >= LIM), ADDR_W'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 7)), $urandom,
            ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
        tick();
      end
    end
    for (int i = 0; i < 10; i++) begin
      idle(5'd0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two sources: the pipeline writeback stage (primary, no backpressure) and a multi-cycle unit such as mult/div (secondary, valid/ready).
- Secondary results wait in a small in-order queue and drain in slots the pipeline leaves free.
- Includes starvation protection that stalls writeback, plus pending-register hazard lookup for decode.
- Sits between the WB stage and the register file's regWrite/writeReg/writeData inputs.

Parameters:
- DEPTH, 4: aux queue entries (power of 2, ≥2).
- STARVE_LIMIT, 8: cycles a live queue head may wait before stall_wb asserts (≥2).
- DATA_W, 32: write data width.
- ADDR_W, 5: register index width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback request (regWrite).
- wb_reg  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline write data.
- aux_valid  in  1  aux result offered.
- aux_ready  out  1  aux result accepted this cycle.
- aux_reg  in  ADDR_W  aux destination register.
- aux_data  in  DATA_W  aux result.
- rf_regWrite  out  1  to register file.
- rf_writeReg  out  ADDR_W  to register file.
- rf_writeData  out  DATA_W  to register file.
- stall_wb  out  1  registered; pipeline must hold WB and drive wb_valid=0.
- q_reg1  in  ADDR_W  decode hazard query, source 1.
- q_reg2  in  ADDR_W  decode hazard query, source 2.
- q_hit1  out  1  q_reg1 has a pending live queue write.
- q_hit2  out  1  q_reg2 has a pending live queue write.
- protocol_err  out  1  sticky; wb_valid seen while stall_wb=1.

Behaviour:
- Reset (rst_n low, async): queue empty, all entries dead, wait_cnt=0, stall_wb=0, protocol_err=0, aux_ready=0. rf_* outputs follow the combinational rules below with an empty queue.
- wb_live = wb_valid && wb_reg!=0.
- Write port (combinational, zero latency):
  - If wb_live: rf_regWrite=1, rf_writeReg=wb_reg, rf_writeData=wb_data.
  - Else if head is valid and live: drive the head entry; it pops at the posedge.
  - Else rf_regWrite=0; rf_writeReg and rf_writeData=0.
- Enqueue:
  - aux_ready = rst_n && count<DEPTH.
  - On aux_valid&&aux_ready the entry is written at the posedge, marked live.
  - aux_reg==0 is accepted but not enqueued (dropped).
  - No same-cycle bypass: an entry can drain one cycle after enqueue at the earliest.
  - Full queue with a simultaneous pop: aux_ready remains 0 that cycle (depends on count only).
- Kill (write-after-write ordering):
  - When wb_live, every live queue entry with reg==wb_reg is marked dead at that posedge, because the newer pipeline write wins.
  - An entry enqueued in the same cycle with the same reg is enqueued live; the aux result is younger.
- Dead head: popped at the posedge without using the port, in any cycle, independent of wb_live.
- Starvation:
  - wait_cnt increments each cycle a live head exists and is not drained.
  - wait_cnt clears on drain or when the queue has no live head.
  - When wait_cnt==STARVE_LIMIT-1 and the head is not draining, stall_wb sets at the next edge.
  - stall_wb clears at the edge on which the live head pops; it covers one entry only.
- Contract violation: wb_valid=1 while stall_wb=1 still gives wb priority, sets protocol_err (cleared only by reset), and keeps stall_wb asserted.
- Hazard lookup (combinational): q_hitN = (q_regN!=0) && any valid, live entry has reg==q_regN. Same-cycle enqueues are not visible.
- Pointers wrap modulo DEPTH; count is ADDR-independent, width clog2(DEPTH)+1.
- Reset mid-operation discards queued entries; aux results are lost.

Decomposition:
- Shared package: ADDR_W, DATA_W, REG_ZERO constant, queue-entry struct {live, reg, data}.
- One natural sub-module: regfile_wr_queue, the DEPTH-entry circular buffer with per-entry live bits, kill-by-register compare, and dual match outputs.
- The arbiter top holds the port mux, wait counter, and stall/err flags.

Test Plan:
- Reset, then aux r5=0x11 with wb idle: aux_ready=1; at cycle +1, rf_regWrite=1, rf_writeReg=5, rf_writeData=0x11; the queue is then empty.
- Four aux writes (r1–r4) while wb writes r9 continuously: aux_ready=0 after the 4th accept; q_hit1=1 for q_reg1=3. At the first idle wb cycle r1 drains, then r2–r4 drain in order.
- Aux r7=0xA enqueued, then wb writes r7=0xB before any drain: the entry is killed and popped without a write; the register file sees only 0xB; q_hit for r7=0 after the kill edge.
- Queue head r6 blocked by wb_valid every cycle, STARVE_LIMIT=8: stall_wb=1 after 8 cycles. The bench drops wb_valid, r6 drains, and stall_wb=0 the following cycle.
- While stall_wb=1 the bench drives wb_valid=1 r2: r2 is written, protocol_err=1 and stays 1, and stall_wb remains high until the head drains.
- Aux r0=0x55 offered: accepted, never written, count unchanged. Assert rst_n=0 mid-drain with 2 entries queued: outputs clear immediately, aux_ready=0, and no further writes occur.
